// File: rtl/imem_loadable.sv
// Loadable synchronous instruction memory: NOP clear sweep after reset, program-load
// write port, registered fetch with misaligned/out-of-range fault flags.
module imem_loadable #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH_LOG2   = 5,
  parameter logic [31:0]           BASE_ADDRESS = 32'h0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic [1:0]            fetch_fault,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  busy
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int TAG_W  = 32 - DEPTH_LOG2 - 2;
  localparam int STAGES = 1;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  typedef struct packed {
    logic [1:0]            fault;
    logic [DATA_WIDTH-1:0] data;
  } fetch_rsp_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] idx, idx_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [STAGES:0]       vld_pipe;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy    = 1'b1;
        idx_nxt = idx + 1'b1;
        if (idx == '1) state_nxt = ST_READY;
      end
      ST_READY: begin
        fetch_ready = 1'b1;
        load_ready  = 1'b1;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Single write port shared by the clear sweep and program load
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  assign wr_en   = busy | (load_en & load_ready);
  assign wr_addr = busy ? idx : load_addr;
  assign wr_data = busy ? NOP_WORD : load_data;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // BASE_ADDRESS holds the tag value that address[31:DEPTH_LOG2+2] must match
  logic                  misalign, miss;
  logic [DEPTH_LOG2-1:0] rd_idx;
  fetch_rsp_t            rsp_nxt, rsp;

  assign misalign    = |fetch_addr[1:0];
  assign miss        = fetch_addr[31:DEPTH_LOG2+2] != BASE_ADDRESS[TAG_W-1:0];
  assign rd_idx      = fetch_addr[DEPTH_LOG2+1:2];
  assign vld_pipe[0] = fetch_req & fetch_ready;

  always_comb begin
    rsp_nxt.fault = {miss, misalign};
    rsp_nxt.data  = (miss | misalign) ? NOP_WORD : mem[rd_idx];
  end

  // Read-first: the read sees mem before this edge's write lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe[STAGES:1] <= '0;
      rsp                <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) rsp <= rsp_nxt;
    end
  end

  assign fetch_valid = vld_pipe[STAGES];
  assign fetch_data  = rsp.data;
  assign fetch_fault = rsp.fault;
endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: directed scenarios plus randomized
// fetch/load traffic against an array-based reference model.
module tb_imem_loadable;
  localparam int DW = 32, DL2 = 5, DEPTH = 32;

  logic           clk = 1'b0, reset_n = 1'b1;
  logic           fetch_req = 1'b0, fetch_ready, fetch_valid;
  logic [31:0]    fetch_addr = '0;
  logic [DW-1:0]  fetch_data;
  logic [1:0]     fetch_fault;
  logic           load_en = 1'b0, load_ready, busy;
  logic [DL2-1:0] load_addr = '0;
  logic [DW-1:0]  load_data = '0;

  always #5 clk = ~clk;

  imem_loadable #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .BASE_ADDRESS(32'h0), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_fault(fetch_fault), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready), .busy(busy));

  int          vectors = 0, miscompares = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_data = '0;
  logic [1:0]  last_fault = '0;

  // Reference model: faults and data straight from the address rules
  function automatic logic [1:0] m_fault(input logic [31:0] a);
    return {a[31:7] != 25'd0, a[1:0] != 2'd0};
  endfunction
  function automatic logic [31:0] m_data(input logic [31:0] a);
    return (m_fault(a) != 2'b00) ? 32'h0 : ref_mem[a[6:2]];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = DL2'(a); load_data = d;
    tick();
    load_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Counts busy cycles after reset release; optionally pokes both ports throughout
  task automatic wait_sweep(input bit poke, output int cyc, output int bad_vld);
    cyc = 0; bad_vld = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (poke) begin
        fetch_req = 1'b1; fetch_addr = 32'h14;
        load_en = 1'b1; load_addr = 5'd5; load_data = 32'hFFFF_FFFF;
      end
      tick();
      cyc++;
      if (fetch_valid !== 1'b0) bad_vld++;
      if (busy !== 1'b1) begin fetch_req = 1'b0; load_en = 1'b0; end
    end
    fetch_req = 1'b0; load_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    last_data = '0; last_fault = '0;
  endtask

  task automatic test_reset();
    int cyc, bad;
    #1 reset_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({busy, fetch_ready, load_ready, fetch_valid, fetch_fault, fetch_data} !== {4'b1000, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got b%b r%b l%b v%b f%b d%h", busy, fetch_ready, load_ready, fetch_valid, fetch_fault, fetch_data);
    end
    reset_n = 1'b1;
    wait_sweep(1'b0, cyc, bad);
    vectors++;
    if (cyc !== 32) begin miscompares++; $display("FAIL sweep_len: got %0d expected 32", cyc); end
    vectors++;
    if ({busy, fetch_ready, load_ready} !== 3'b011) begin
      miscompares++; $display("FAIL ready_after_sweep: got %b expected 011", {busy, fetch_ready, load_ready});
    end
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h7C;
    vectors++;
    if ({fetch_valid, fetch_fault, fetch_data} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++; $display("FAIL nop_fetch_0: got v%b f%b d%h expected v1 f00 d0", fetch_valid, fetch_fault, fetch_data);
    end
    tick();
    fetch_req = 1'b0;
    vectors++;
    if ({fetch_valid, fetch_fault, fetch_data} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++; $display("FAIL nop_fetch_7c: got v%b f%b d%h expected v1 f00 d0", fetch_valid, fetch_fault, fetch_data);
    end
    tick();
  endtask

  task automatic test_load_fetch();
    do_load(0, 32'h8C02_0004);
    do_load(9, 32'h10E0_FFFA);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h24;
    vectors++;
    if ({fetch_valid, fetch_fault, fetch_data} !== {1'b1, 2'b00, 32'h8C02_0004}) begin
      miscompares++; $display("FAIL b2b_first: got v%b f%b d%h expected v1 f00 d8c020004", fetch_valid, fetch_fault, fetch_data);
    end
    tick();
    fetch_req = 1'b0;
    vectors++;
    if ({fetch_valid, fetch_fault, fetch_data} !== {1'b1, 2'b00, 32'h10E0_FFFA}) begin
      miscompares++; $display("FAIL b2b_second: got v%b f%b d%h expected v1 f00 d10e0fffa", fetch_valid, fetch_fault, fetch_data);
    end
    tick();
    vectors++;
    if ({fetch_valid, fetch_fault, fetch_data} !== {1'b0, 2'b00, 32'h10E0_FFFA}) begin
      miscompares++; $display("FAIL idle_hold: got v%b f%b d%h expected v0 f00 d10e0fffa", fetch_valid, fetch_fault, fetch_data);
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3] = '{32'h6, 32'h80, 32'h82};
    logic [1:0]  exp_f [3] = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = addrs[i];
      tick();
      fetch_req = 1'b0;
      vectors++;
      if ({fetch_valid, fetch_fault, fetch_data} !== {1'b1, exp_f[i], 32'h0}) begin
        miscompares++;
        $display("FAIL fault_%h: got v%b f%b d%h expected v1 f%b d0", addrs[i], fetch_valid, fetch_fault, fetch_data, exp_f[i]);
      end
    end
    tick();
  endtask

  task automatic test_same_cycle();
    fetch_req = 1'b1; fetch_addr = 32'hC;
    load_en = 1'b1; load_addr = 5'd3; load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0; ref_mem[3] = 32'hDEAD_BEEF;
    vectors++;
    if ({fetch_valid, fetch_data} !== {1'b1, 32'h0}) begin
      miscompares++; $display("FAIL read_first_old: got v%b d%h expected v1 d0", fetch_valid, fetch_data);
    end
    tick();
    fetch_req = 1'b0;
    vectors++;
    if ({fetch_valid, fetch_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      miscompares++; $display("FAIL read_first_new: got v%b d%h expected v1 ddeadbeef", fetch_valid, fetch_data);
    end
    tick();
  endtask

  task automatic test_sweep_ignores();
    int cyc, bad;
    reset_n = 1'b0; #2 reset_n = 1'b1;
    wait_sweep(1'b1, cyc, bad);
    vectors++;
    if (cyc !== 32 || bad !== 0) begin
      miscompares++; $display("FAIL sweep_ignores: got cyc %0d stray_valid %0d expected 32 0", cyc, bad);
    end
    fetch_req = 1'b1; fetch_addr = 32'h14;
    tick();
    fetch_req = 1'b0;
    vectors++;
    if ({fetch_valid, fetch_fault, fetch_data} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++; $display("FAIL word5_after_sweep: got v%b f%b d%h expected v1 f00 d0", fetch_valid, fetch_fault, fetch_data);
    end
    tick();
  endtask

  task automatic test_reset_midsweep();
    int cyc, bad;
    do_load(0, 32'h8C02_0004);
    do_load(9, 32'h10E0_FFFA);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_req = 1'b0;
    reset_n = 1'b0; #1;
    vectors++;
    if ({busy, fetch_ready, load_ready, fetch_valid, fetch_fault, fetch_data} !== {4'b1000, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_midfetch: got b%b r%b l%b v%b f%b d%h", busy, fetch_ready, load_ready, fetch_valid, fetch_fault, fetch_data);
    end
    #2 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0; #1;
    vectors++;
    if ({busy, fetch_ready, load_ready, fetch_valid} !== 4'b1000) begin
      miscompares++; $display("FAIL reset_midsweep: got %b expected 1000", {busy, fetch_ready, load_ready, fetch_valid});
    end
    #2 reset_n = 1'b1;
    wait_sweep(1'b0, cyc, bad);
    vectors++;
    if (cyc !== 32) begin miscompares++; $display("FAIL resweep_len: got %0d expected 32", cyc); end
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h24;
    vectors++;
    if ({fetch_valid, fetch_data} !== {1'b1, 32'h0}) begin
      miscompares++; $display("FAIL cleared_word0: got v%b d%h expected v1 d0", fetch_valid, fetch_data);
    end
    tick();
    fetch_req = 1'b0;
    vectors++;
    if ({fetch_valid, fetch_data} !== {1'b1, 32'h0}) begin
      miscompares++; $display("FAIL cleared_word9: got v%b d%h expected v1 d0", fetch_valid, fetch_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic        req, le, exp_v;
    logic [31:0] a, ld;
    int          la;
    for (int n = 0; n < 400; n++) begin
      req = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        6:       a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
        7:       a = ($urandom | 32'h80) & ~32'h3;
        8:       a = $urandom | 32'h81;
        9:       a = $urandom;
        default: a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      endcase
      le = ($urandom_range(0, 2) == 0);
      la = $urandom_range(0, 31);
      ld = $urandom;
      exp_v = req;
      if (req) begin last_fault = m_fault(a); last_data = m_data(a); end
      fetch_req = req; fetch_addr = a;
      load_en = le; load_addr = DL2'(la); load_data = ld;
      tick();
      if (le) ref_mem[la] = ld;
      vectors++;
      if ({fetch_valid, fetch_fault, fetch_data} !== {exp_v, last_fault, last_data}) begin
        miscompares++;
        $display("FAIL random_%0d: got v%b f%b d%h expected v%b f%b d%h", n,
                 fetch_valid, fetch_fault, fetch_data, exp_v, last_fault, last_data);
      end
    end
    fetch_req = 1'b0; load_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_faults();
    test_same_cycle();
    test_sweep_ignores();
    test_reset_midsweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, clocked successor to the fixed-contents instruction ROM.
- Synchronous instruction memory for the single-cycle/multicycle MIPS subset datapath: word-addressed array of DEPTH words, base-address decoding, registered fetch with request/valid handshake.
- Program-load write port replaces hard-coded contents; reset-triggered clear sweep fills the array with NOP (32'h0000_0000, sll $0,$0,0).
- Alignment and range errors are reported as registered fault flags alongside the fetch response.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
DEPTH_LOG2, 5, log2 of number of words (default 32 words)
BASE_ADDRESS, 0, value address[31:DEPTH_LOG2+2] must equal for a hit
NOP_WORD, 32'h0000_0000, value written by clear sweep

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request, sampled when fetch_ready=1
fetch_addr  in  32  byte address of instruction
fetch_ready  out  1  block accepts a fetch this cycle
fetch_valid  out  1  response valid, one-cycle pulse
fetch_data  out  DATA_WIDTH  instruction word
fetch_fault  out  2  bit0 misaligned, bit1 out-of-range; valid with fetch_valid
load_en  in  1  program-load write strobe
load_addr  in  DEPTH_LOG2  word index to write
load_data  in  DATA_WIDTH  word to write
load_ready  out  1  write port accepts writes
busy  out  1  clear sweep in progress

Behaviour:
- Reset (reset_n=0, immediate): state=CLEAR, sweep index=0, fetch_ready=0, load_ready=0, busy=1, fetch_valid=0, fetch_data=0, fetch_fault=0. Array contents not touched by reset itself.
- State CLEAR: each cycle write NOP_WORD to array[index], index++. After writing index DEPTH-1, go to READY next cycle. Sweep takes exactly DEPTH cycles after reset release. busy=1 throughout CLEAR.
- Requests during CLEAR: fetch_req and load_en ignored, no response, no fault.
- State READY: fetch_ready=1, load_ready=1, busy=0. Stays READY until reset.
- Fetch acceptance: fetch_req=1 && fetch_ready=1 at edge N gives fetch_valid=1 for exactly the cycle after edge N. Back-to-back requests give back-to-back responses; throughput one per cycle. fetch_valid=0 when no request was accepted.
- Hit condition: fetch_addr[31:DEPTH_LOG2+2]==BASE_ADDRESS. Word index = fetch_addr[DEPTH_LOG2+1:2].
- Misaligned (fetch_addr[1:0]!=0): fault bit0=1, fetch_data=NOP_WORD, array not read.
- Miss: fault bit1=1, fetch_data=NOP_WORD. Both bits set if both conditions hold.
- fetch_data and fetch_fault hold their last values while fetch_valid=0.
- Load: load_en=1 && load_ready=1 writes load_data to array[load_addr] at the edge. load_addr is always in range.
- Fetch and load to the same word in the same cycle: read-first. The response carries the old word; the new word is visible to fetches accepted from the next cycle.
- Reset asserted mid-sweep or mid-fetch: pending response is dropped (fetch_valid=0) and the sweep restarts from index 0 after release.

Test Plan:
- Reset release, DEPTH=32 -> busy=1 for exactly 32 cycles, then fetch_ready=load_ready=1. Fetch 0x0, 0x7C -> data 0x0000_0000, fault 0.
- Load word 0 = 0x8C02_0004, word 9 = 0x10E0_FFFA; fetch 0x0 then 0x24 back-to-back -> valid on two consecutive cycles, data 0x8C02_0004 then 0x10E0_FFFA, fault 0.
- Fetch 0x6 -> fault=2'b01, data 0x0; fetch 0x80 (BASE_ADDRESS=0) -> fault=2'b10; fetch 0x82 -> fault=2'b11.
- Same cycle: load word 3 = 0xDEAD_BEEF and fetch 0xC (old word 0x0) -> response 0x0. Next-cycle fetch 0xC -> 0xDEAD_BEEF.
- fetch_req and load_en asserted during the sweep -> no fetch_valid, array[5] still 0 after the sweep.
- reset_n pulsed low at sweep index 10 after words were loaded -> outputs reset immediately, full 32-cycle sweep restarts, previously loaded words read 0x0.
